// File: rtl/mem_responder_pkg.sv
// Shared types for the memory responder: access size codes
// and FSM state encodings.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian byte-lane steering for one aligned word.
// Ports: size/off/wdata in -> be/wword (write lanes),
// rword in -> rdata (right-justified, zero-extended), bad flag.
module mem_lane_align
  import mem_responder_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] rdata,
  output logic        bad
);

  // be[3] / word[31:24] is the byte at the aligned base.
  // Byte at offset o lives 8*(3-o) bits up; 3-o == ~o.
  logic [4:0] sh_b;
  logic [4:0] sh_h;

  assign sh_b = {~off, 3'b000};
  assign sh_h = {~off[1], 4'b0000};

  always_comb begin
    be    = 4'b0000;
    wword = 32'd0;
    rdata = 32'd0;
    bad   = 1'b0;
    case (size)
      SIZE_BYTE: begin
        be    = 4'b1000 >> off;
        wword = {24'd0, wdata[7:0]} << sh_b;
        rdata = {24'd0, 8'(rword >> sh_b)};
      end
      SIZE_HALF: begin
        bad   = off[0];
        be    = 4'b1100 >> off;
        wword = {16'd0, wdata[15:0]} << sh_h;
        rdata = {16'd0, 16'(rword >> sh_h)};
      end
      SIZE_WORD: begin
        bad   = (off != 2'b00);
        be    = 4'b1111;
        wword = wdata;
        rdata = rword;
      end
      default: bad = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: one request at a time, programmable
// wait states, one-cycle response; big-endian byte storage.
// Ports: clk, reset (async, active-low), req_valid/req_ready,
// req_wr/req_size/req_addr/req_wdata, rsp_valid/rsp_rdata/rsp_err.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] LAST =
    (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

  state_e state;
  state_e nxt;

  logic [CNT_W-1:0] cnt;
  logic             rdy;

  logic        wr_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic        cur_wr;
  logic [1:0]  cur_size;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;

  logic              accept;
  logic              enter_resp;
  logic [ADDR_W-1:0] base;
  logic [31:0]       rword;
  logic [31:0]       wword;
  logic [31:0]       rdata;
  logic [3:0]        be;
  logic              bad;
  logic              oor;
  logic              err;

  logic [7:0] mem [0:DEPTH-1];

  // Registered ready: low while in reset, so nothing can be
  // accepted (or committed) before the first edge after release.
  assign req_ready = rdy;
  assign accept    = req_valid && rdy;

  // With zero wait states the access happens on the accept
  // edge itself, so it must use the live request fields.
  assign cur_wr    = (state == IDLE) ? req_wr    : wr_q;
  assign cur_size  = (state == IDLE) ? req_size  : size_q;
  assign cur_addr  = (state == IDLE) ? req_addr  : addr_q;
  assign cur_wdata = (state == IDLE) ? req_wdata : wdata_q;

  assign base = {cur_addr[ADDR_W-1:2], 2'b00};
  assign oor  = (cur_addr >> ADDR_W) != 32'd0;
  assign err  = bad || oor;

  assign rword = {mem[base],
                  mem[base + ADDR_W'(1)],
                  mem[base + ADDR_W'(2)],
                  mem[base + ADDR_W'(3)]};

  mem_lane_align u_align (
    .size  (size_e'(cur_size)),
    .off   (cur_addr[1:0]),
    .wdata (cur_wdata),
    .rword (rword),
    .be    (be),
    .wword (wword),
    .rdata (rdata),
    .bad   (bad)
  );

  assign enter_resp = (nxt == RESP) && (state != RESP);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) nxt = RESP;
          else                  nxt = WAIT;
        end
      end
      WAIT: if (cnt == LAST) nxt = RESP;
      RESP: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdy       <= 1'b0;
      cnt       <= '0;
      wr_q      <= 1'b0;
      size_q    <= 2'b00;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      rdy <= (nxt == IDLE);
      if (accept) begin
        cnt     <= '0;
        wr_q    <= req_wr;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end else if (state == WAIT) begin
        cnt <= cnt + 1'b1;
      end
      rsp_valid <= enter_resp;
      if (enter_resp) begin
        rsp_err   <= err;
        rsp_rdata <= (err || cur_wr) ? 32'd0 : rdata;
      end else begin
        rsp_err   <= 1'b0;
        rsp_rdata <= 32'd0;
      end
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (enter_resp && cur_wr && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[3-i])
          mem[base + ADDR_W'(i)] <= wword[31-8*i -: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: three instances with
// 1, 3 and 0 wait states driven by one directed sequence.
module tb_mem_responder;

  typedef struct {
    logic [31:0] rd;
    logic        er;
    int          due;
  } exp_t;

  logic        clk;
  logic [2:0]  rst;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [2:0]  req_wr;
  logic [1:0]  req_size  [3];
  logic [31:0] req_addr  [3];
  logic [31:0] req_wdata [3];
  logic [2:0]  rsp_valid;
  logic [31:0] rsp_rdata [3];
  logic [2:0]  rsp_err;

  int cyc;
  int cmp;
  int errs;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_responder #(
      .ADDR_W      (8),
      .WAIT_CYCLES (g == 0 ? 1 : (g == 1 ? 3 : 0))
    ) u_dut (
      .clk       (clk),
      .reset     (rst[g]),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_wr    (req_wr[g]),
      .req_size  (req_size[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_rdata (rsp_rdata[g]),
      .rsp_err   (rsp_err[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wc(int d);
    return (d == 0) ? 1 : ((d == 1) ? 3 : 0);
  endfunction

  task automatic check(string tag, logic [31:0] obs,
                       logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(int d, exp_t e);
    case (d)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rsp_valid[d] === 1'b1) begin
        exp_t e;
        logic have;
        have = 1'b0;
        case (d)
          0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
          1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
          default:
             if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
        endcase
        if (!have) begin
          check($sformatf("unexpected_rsp%0d", d),
                {31'd0, rsp_valid[d]}, 32'd0);
        end else begin
          check($sformatf("rdata%0d", d), rsp_rdata[d], e.rd);
          check($sformatf("err%0d", d), {31'd0, rsp_err[d]},
                {31'd0, e.er});
          check($sformatf("latency%0d", d), 32'(cyc), 32'(e.due));
          check($sformatf("ready_in_resp%0d", d),
                {31'd0, req_ready[d]}, 32'd0);
        end
      end
    end
  end

  // Drive one request; expectation is queued the negedge before
  // the accept edge. With hold, valid stays high and junk fields
  // are presented for one busy cycle.
  task automatic send(int d, logic wr, logic [1:0] sz,
                      logic [31:0] a, logic [31:0] wd,
                      logic [31:0] rd, logic er, logic hold);
    exp_t e;
    int n;
    req_wr[d]    = wr;
    req_size[d]  = sz;
    req_addr[d]  = a;
    req_wdata[d] = wd;
    req_valid[d] = 1'b1;
    n = 0;
    @(negedge clk);
    while (req_ready[d] !== 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (req_ready[d] !== 1'b1) begin
      check("ready_wait", {31'd0, req_ready[d]}, 32'd1);
      req_valid[d] = 1'b0;
    end else begin
      e.rd  = rd;
      e.er  = er;
      e.due = cyc + 1 + wc(d);
      push(d, e);
      @(posedge clk);
      #1;
      if (hold) begin
        check("ready_after_accept", {31'd0, req_ready[d]}, 32'd0);
        req_wr[d]    = 1'b1;
        req_size[d]  = 2'b10;
        req_addr[d]  = 32'h40;
        req_wdata[d] = 32'hFFFF_FFFF;
        @(negedge clk);
      end else begin
        req_valid[d] = 1'b0;
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(q0.size() + q1.size() + q2.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    cmp  = 0;
    errs = 0;
    rst  = '1;
    req_valid = '0;
    req_wr    = '0;
    for (int d = 0; d < 3; d++) begin
      req_size[d]  = 2'b00;
      req_addr[d]  = 32'd0;
      req_wdata[d] = 32'd0;
    end
    #1 rst = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rsp_valid", {31'd0, rsp_valid[0]}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata[0], 32'd0);
    check("rst_rsp_err", {31'd0, rsp_err[0]}, 32'd0);
    rst = '1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, req_ready[0]}, 32'd1);

    // Word write/read, byte merge, sub-word reads (1 wait state)
    send(0, 1'b1, 2'b10, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0);
    send(0, 1'b0, 2'b10, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    send(0, 1'b1, 2'b00, 32'h11, 32'h1234_56AA, 32'h0, 1'b0, 1'b0);
    send(0, 1'b0, 2'b10, 32'h10, 32'h0, 32'hDEAA_BEEF, 1'b0, 1'b0);
    send(0, 1'b0, 2'b00, 32'h13, 32'h0, 32'h0000_00EF, 1'b0, 1'b0);
    send(0, 1'b0, 2'b01, 32'h12, 32'h0, 32'h0000_BEEF, 1'b0, 1'b0);
    send(0, 1'b0, 2'b00, 32'h10, 32'h0, 32'h0000_00DE, 1'b0, 1'b0);

    // Error cases leave storage untouched
    send(0, 1'b1, 2'b01, 32'h13, 32'h0000_1111, 32'h0, 1'b1, 1'b0);
    send(0, 1'b1, 2'b10, 32'h12, 32'h2222_2222, 32'h0, 1'b1, 1'b0);
    send(0, 1'b0, 2'b11, 32'h10, 32'h0, 32'h0, 1'b1, 1'b0);
    send(0, 1'b0, 2'b10, 32'h10, 32'h0, 32'hDEAA_BEEF, 1'b0, 1'b0);
    send(0, 1'b0, 2'b10, 32'h100, 32'h0, 32'h0, 1'b1, 1'b0);
    send(0, 1'b1, 2'b00, 32'h8000_0010, 32'h55, 32'h0, 1'b1, 1'b0);
    send(0, 1'b0, 2'b10, 32'h10, 32'h0, 32'hDEAA_BEEF, 1'b0, 1'b0);
    drain();

    // Valid held high across three requests, junk while busy
    send(0, 1'b1, 2'b10, 32'h40, 32'h0102_0304, 32'h0, 1'b0, 1'b1);
    send(0, 1'b0, 2'b01, 32'h42, 32'h0, 32'h0000_0304, 1'b0, 1'b1);
    send(0, 1'b0, 2'b00, 32'h40, 32'h0, 32'h0000_0001, 1'b0, 1'b1);
    req_valid[0] = 1'b0;
    drain();
    send(0, 1'b0, 2'b10, 32'h40, 32'h0, 32'h0102_0304, 1'b0, 1'b0);
    drain();

    // Reset mid-write on the 3-wait-state instance
    send(1, 1'b1, 2'b10, 32'h20, 32'h1122_3344, 32'h0, 1'b0, 1'b0);
    send(1, 1'b0, 2'b10, 32'h20, 32'h0, 32'h1122_3344, 1'b0, 1'b0);
    drain();
    req_wr[1]    = 1'b1;
    req_size[1]  = 2'b00;
    req_addr[1]  = 32'h20;
    req_wdata[1] = 32'h55;
    req_valid[1] = 1'b1;
    @(negedge clk);
    check("abort_ready", {31'd0, req_ready[1]}, 32'd1);
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    @(posedge clk);
    #1 rst[1] = 1'b0;
    #1;
    check("abort_rsp_valid", {31'd0, rsp_valid[1]}, 32'd0);
    check("abort_rsp_rdata", rsp_rdata[1], 32'd0);
    check("abort_rsp_err", {31'd0, rsp_err[1]}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst[1] = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    send(1, 1'b0, 2'b10, 32'h20, 32'h0, 32'h1122_3344, 1'b0, 1'b0);
    send(1, 1'b0, 2'b00, 32'h23, 32'h0, 32'h0000_0044, 1'b0, 1'b0);
    drain();

    // Zero wait states
    send(2, 1'b1, 2'b10, 32'h80, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b0);
    send(2, 1'b0, 2'b10, 32'h80, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b0);
    send(2, 1'b1, 2'b01, 32'h80, 32'h0000_1234, 32'h0, 1'b0, 1'b0);
    send(2, 1'b0, 2'b10, 32'h80, 32'h0, 32'h1234_F00D, 1'b0, 1'b0);
    send(2, 1'b0, 2'b00, 32'h83, 32'h0, 32'h0000_000D, 1'b0, 1'b0);
    send(2, 1'b0, 2'b01, 32'h81, 32'h0, 32'h0, 1'b1, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             cmp, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout compared=%0d mismatched=%0d", cmp, errs);
    $fatal(1, "timeout");
  end

endmodule
